// File: rtl/sram_like_arbiter.sv
// Two-to-one sram-like port arbiter with an in-order ID queue that routes responses back.
// Optional macro ARB_ROUND_ROBIN_EN switches IDLE priority from fixed data-first to alternating.
module sram_like_arbiter #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int QPTR_W          = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam int DEPTH = 1 << QPTR_W;
   localparam int CNT_W = QPTR_W + 1;

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

   state_t            state;
   logic [QPTR_W-1:0] rd_ptr;
   logic [QPTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0]  count;
   logic              id_q [DEPTH];

   logic full;
   logic empty;
   logic pick_data;
   logic gnt_data;
   logic accept;
   logic pop;

   function automatic logic [QPTR_W-1:0] ptr_inc(input logic [QPTR_W-1:0] p);
      return (p == QPTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full  = (count == CNT_W'(MAX_OUTSTANDING));
   assign empty = (count == '0);

`ifdef ARB_ROUND_ROBIN_EN
   logic prefer_inst;

   assign pick_data = prefer_inst ? !inst_req : data_req;

   // Alternate after each accept: a data accept makes inst the next preferred requester.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         prefer_inst <= 1'b0;
      end else if (accept) begin
         prefer_inst <= gnt_data;
      end
   end
`else
   assign pick_data = data_req;
`endif

   always_comb begin
      gnt_data = pick_data;
      case (state)
         GNT_I:   gnt_data = 1'b0;
         GNT_D:   gnt_data = 1'b1;
         default: gnt_data = pick_data;
      endcase
   end

   // Full depends only on the registered count, so mem_data_ok never reaches mem_req.
   assign mem_req   = resetn & !full & (gnt_data ? data_req : inst_req);
   assign mem_wr    = gnt_data ? data_wr    : inst_wr;
   assign mem_size  = gnt_data ? data_size  : inst_size;
   assign mem_wstrb = gnt_data ? data_wstrb : inst_wstrb;
   assign mem_addr  = gnt_data ? data_addr  : inst_addr;
   assign mem_wdata = gnt_data ? data_wdata : inst_wdata;

   assign accept       = mem_req & mem_addr_ok;
   assign inst_addr_ok = accept & !gnt_data;
   assign data_addr_ok = accept & gnt_data;

   assign pop          = mem_data_ok & !empty;
   assign inst_data_ok = pop & !id_q[rd_ptr];
   assign data_data_ok = pop & id_q[rd_ptr];
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (mem_req && !mem_addr_ok) begin
                  state <= gnt_data ? GNT_D : GNT_I;
               end
            end
            GNT_I, GNT_D: begin
               if (accept) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            id_q[i] <= 1'b0;
         end
      end else begin
         if (accept) begin
            id_q[wr_ptr] <= gnt_data;
            wr_ptr       <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
